array_seq: RTL and testbench
============================

// Module: array_seq
// PURPOSE
// Burst command sequencer in front of array_ctrl. Accepts one host command (op, base addr, length),
// expands it into one array op per cycle with an incrementing address, and streams write/MAC
// operands in. Read/MAC results are collected at a fixed array latency and returned to the host.
// Sits between the host command interface and array_ctrl's op_code/addr/data_in inputs.
// PARAMETERS
// RD_LAT   2   cycles from arr_op_code issue to valid arr_rd_data (1..7)
// PORTS
// clk          in   1   system clock; all state on posedge
// rst_n        in   1   asynchronous active-low reset
// cmd_valid    in   1   host command valid
// cmd_ready    out  1   high only in IDLE; command accepted on cmd_valid&cmd_ready
// cmd_op       in   2   01 WRITE, 10 READ, 11 MAC; 00 accepted as a no-op burst
// cmd_addr     in   9   burst base address
// cmd_len      in   4   burst length minus one (0 -> 1 op, 15 -> 16 ops)
// wr_valid     in   1   operand beat valid (WRITE/MAC)
// wr_ready     out  1   operand beat consumed this cycle
// wr_data      in  16   operand beat
// arr_op_code  out  2   to array_ctrl op_code; 00 = idle/stall
// arr_addr     out  9   to array_ctrl addr
// arr_data_in  out 16   to array_ctrl data_in
// arr_rd_data  in  16   array result (data_op path), valid RD_LAT cycles after READ/MAC issue
// rd_valid     out  1   result beat valid (no backpressure)
// rd_data      out 16   result beat
// busy         out  1   state != IDLE
// done         out  1   one-cycle pulse at burst completion
// BEHAVIOUR
// - Reset: state IDLE; arr_op_code=0, arr_addr=0, arr_data_in=0, rd_valid=0, rd_data=0, done=0,
//   busy=0, wr_ready=0, issue pipe cleared. Reset mid-burst aborts it; no done, in-flight results dropped.
// - All arr_* outputs and rd_* outputs are registered.
// - FSM: IDLE -> ISSUE on accept (latch op, addr, remaining=cmd_len). ISSUE -> DRAIN after last op issued.
//   DRAIN counts RD_LAT cycles, then asserts done for one cycle and returns to IDLE.
// - ISSUE, READ: one op per cycle, arr_op_code=10, arr_addr=current addr; never stalls.
// - ISSUE, WRITE/MAC: wr_ready=1; if wr_valid, issue op with arr_data_in=wr_data; else arr_op_code=00
//   that cycle, addr/count unchanged (stall bubble). wr_ready=0 outside ISSUE and for READ bursts.
// - cmd_op=00: issues len+1 bubbles (arr_op_code=00), addr still advances; done as normal.
// - Address increments by 1 per issued op, wraps 511 -> 0 inside a burst.
// - Issue pipe: RD_LAT-deep shift of "expects result" bit (set for READ/MAC issues). When its tail
//   is set, rd_valid=1 and rd_data=arr_rd_data on the following edge. Results return in issue order;
//   count equals number of READ/MAC ops issued.
// - done asserts in the cycle after the DRAIN count expires; cmd_ready goes high the same cycle, so a
//   new command is accepted no earlier than that cycle (no overlap of bursts).
// - cmd_valid while not IDLE is ignored (held off by cmd_ready=0).
// STRUCTURE
// - Shared package array_pkg: op encodings OP_NOP/OP_WRITE/OP_READ/OP_MAC, ADDR_W=9, DATA_W=16,
//   LEN_W=4, FSM state typedef {IDLE, ISSUE, DRAIN}.
// - One sub-module: array_seq_rdpipe (RD_LAT-deep valid shift + result capture register).
// TESTING
// - Reset mid-burst: READ addr 5 len 7, deassert rst_n at op 3 -> all outputs 0, no done, no rd_valid after.
// - READ addr 0x1FE len 3, RD_LAT=2 -> arr_addr 1FE,1FF,000,001 on consecutive cycles; 4 rd_valid beats
//   starting 3 cycles after first issue, data = arr_rd_data sampled; done 1 cycle after DRAIN.
// - WRITE addr 10 len 2, wr_valid low on 2nd beat for 3 cycles -> 3 op_code=00 bubbles, addr held at 11,
//   arr_data_in matches wr_data per issued op; 0 rd_valid beats.
// - MAC addr 0 len 0, wr_data=0xA5A5 -> single op 11 addr 0 data A5A5; one rd_valid; done pulse once.
// - cmd_valid held high during busy -> cmd_ready=0, second command accepted only on done cycle.
// - cmd_op=00 len 15 -> 16 bubble cycles, no wr_ready, no rd_valid, done pulse.

Source files
------------

// File: rtl/array_pkg.sv
// -----------------------------------------------------------------------------
// array_pkg
// Shared definitions for the array burst sequencer:
//   - bus widths (address, data, burst length, drain counter)
//   - array op encodings as seen on array_ctrl's op_code input
//   - sequencer FSM state type
//   - small helpers that classify an op by operand/result usage
// -----------------------------------------------------------------------------
package array_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
  // Drain counter width; covers read latencies 1..7.
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_MAC   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Op consumes one operand beat from the host per issue.
  function automatic logic op_has_operand(input op_e op);
    return (op == OP_WRITE) || (op == OP_MAC);
  endfunction

  // Op produces one result beat from the array per issue.
  function automatic logic op_has_result(input op_e op);
    return (op == OP_READ) || (op == OP_MAC);
  endfunction

endpackage

// File: rtl/array_seq_rdpipe.sv
// -----------------------------------------------------------------------------
// array_seq_rdpipe
// Result return path. Tracks which issued array ops will produce a result and
// captures the array's read data exactly when it becomes valid.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset (clears pipe and outputs)
//   expect_i       in   the op currently on arr_op_code expects a result
//   arr_rd_data_i  in   array result data
//   rd_valid_o     out  result beat valid (registered)
//   rd_data_o      out  result beat data (registered, holds between beats)
//
// expect_i is taken from the registered op output, so pipe stage k is set
// k+1 cycles after the op was presented to the array. The tail stage
// (index RD_LAT-1) therefore lines up with the cycle arr_rd_data is valid,
// and the result is registered on that edge.
// -----------------------------------------------------------------------------
module array_seq_rdpipe
  import array_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              expect_i,
  input  logic [DATA_W-1:0] arr_rd_data_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [RD_LAT-1:0] pipe_q;
  logic [RD_LAT-1:0] pipe_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              tail;

  assign pipe_d[0] = expect_i;

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_shift
      assign pipe_d[gi] = pipe_q[gi-1];
    end
  endgenerate

  assign tail = pipe_q[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      pipe_q     <= pipe_d;
      rd_valid_q <= tail;
      if (tail) begin
        rd_data_q <= arr_rd_data_i;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/array_seq.sv
// -----------------------------------------------------------------------------
// array_seq
// Burst command sequencer in front of array_ctrl. One host command
// (op, base address, length-1) is expanded into one array op per cycle with
// an incrementing, 9-bit wrapping address. WRITE/MAC bursts pull one operand
// beat per op from the wr_* stream and stall (op_code 00, address held) when
// no beat is offered. READ/MAC results come back through array_seq_rdpipe.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; ready only while IDLE
//   cmd_op               01 WRITE, 10 READ, 11 MAC, 00 no-op burst
//   cmd_addr, cmd_len    burst base address, burst length minus one
//   wr_valid/wr_ready    operand beat handshake (wr_ready = beat taken now)
//   wr_data              operand beat
//   arr_op_code          array op (00 = idle/stall), registered
//   arr_addr             array address, registered
//   arr_data_in          array write/MAC operand, registered
//   arr_rd_data          array result, valid RD_LAT cycles after the op
//   rd_valid, rd_data    result beat, registered, no backpressure
//   busy                 sequencer not IDLE
//   done                 one-cycle pulse on return to IDLE after a burst
//
// Timing: the issue decision is made in an ISSUE cycle and appears on arr_*
// the following cycle. After the last issue, DRAIN lasts RD_LAT cycles and
// done is raised together with the return to IDLE, so a new command can be
// accepted in the done cycle. The final result beat of a burst is presented
// on rd_* one cycle after done.
// -----------------------------------------------------------------------------
module array_seq
  import array_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic [1:0]        arr_op_code,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [DATA_W-1:0] arr_data_in,
  input  logic [DATA_W-1:0] arr_rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(RD_LAT - 1);

  state_e            state_q,    state_d;
  op_e               op_q,       op_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [LEN_W-1:0]  remain_q,   remain_d;
  logic [CNT_W-1:0]  drain_q,    drain_d;
  op_e               arr_op_q,   arr_op_d;
  logic [ADDR_W-1:0] arr_addr_q, arr_addr_d;
  logic [DATA_W-1:0] arr_data_q, arr_data_d;
  logic              done_q,     done_d;

  logic              in_issue;
  logic              step;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      remain_q   <= '0;
      drain_q    <= '0;
      arr_op_q   <= OP_NOP;
      arr_addr_q <= '0;
      arr_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      drain_q    <= drain_d;
      arr_op_q   <= arr_op_d;
      arr_addr_q <= arr_addr_d;
      arr_data_q <= arr_data_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  assign in_issue = (state_q == ISSUE);
  // A READ or no-op burst advances every ISSUE cycle; operand bursts advance
  // only when the host offers a beat.
  assign step     = in_issue && (!op_has_operand(op_q) || wr_valid);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    drain_d    = drain_q;
    arr_op_d   = OP_NOP;
    arr_addr_d = arr_addr_q;
    arr_data_d = arr_data_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d     = op_e'(cmd_op);
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        // The address is presented on stall cycles too, so a bubble shows
        // the address the pending op will use.
        arr_addr_d = addr_q;
        if (step) begin
          // A no-op burst issues OP_NOP here, i.e. a bubble that still
          // advances the address and count.
          arr_op_d = op_q;
          if (op_has_operand(op_q)) begin
            arr_data_d = wr_data;
          end
          addr_d = addr_q + ADDR_W'(1);
          if (remain_q == '0) begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end else begin
            remain_d = remain_q - LEN_W'(1);
          end
        end
      end

      DRAIN: begin
        if (drain_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign wr_ready    = in_issue && op_has_operand(op_q);
  assign done        = done_q;
  assign arr_op_code = arr_op_q;
  assign arr_addr    = arr_addr_q;
  assign arr_data_in = arr_data_q;

  // ---------------------------------------------------------------------------
  // Result return path
  // ---------------------------------------------------------------------------
  array_seq_rdpipe #(
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .expect_i      (op_has_result(arr_op_q)),
    .arr_rd_data_i (arr_rd_data),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data)
  );

endmodule

// File: tb/tb_array_seq.sv
module tb_array_seq;

  localparam int RD_LAT = 2;
  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_WR  = 2'b01;
  localparam logic [1:0] C_RD  = 2'b10;
  localparam logic [1:0] C_MAC = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [8:0]  cmd_addr = 9'd0;
  logic [3:0]  cmd_len = 4'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = 16'd0;
  logic [1:0]  arr_op_code;
  logic [8:0]  arr_addr;
  logic [15:0] arr_data_in;
  logic [15:0] arr_rd_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  array_seq #(.RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .arr_op_code (arr_op_code),
    .arr_addr    (arr_addr),
    .arr_data_in (arr_data_in),
    .arr_rd_data (arr_rd_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Array contents as seen by the sequencer: a fixed function of the address.
  function automatic logic [15:0] mem_val(input logic [8:0] a);
    return {a[6:0], a} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] beat_data(input logic [15:0] base, input int i);
    return base + 16'(i) * 16'h0111;
  endfunction

  // Array model: result for a READ/MAC op appears RD_LAT cycles after the op.
  logic [15:0] dl_q [RD_LAT];
  always @(posedge clk) begin
    dl_q[0] <= (arr_op_code == C_RD || arr_op_code == C_MAC) ? mem_val(arr_addr)
                                                             : (16'hBAD0 ^ cyc[15:0]);
    for (int i = 1; i < RD_LAT; i++) dl_q[i] <= dl_q[i-1];
  end
  assign arr_rd_data = dl_q[RD_LAT-1];

  typedef struct {
    logic [1:0]  op;
    logic [8:0]  addr;
    logic [15:0] data;
    bit          chk_data;
    bit          last;
  } op_exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [8:0]  addr;
    logic [3:0]  len;
    logic [15:0] dbase;
    int          stall_beat;
    int          stall_cyc;
    int          exp_cycles;  // accept cycle to done cycle
    int          exp_rd;      // result beats
    int          exp_wrr;     // cycles with wr_ready high
    int          exp_gaps;    // bubbles between first and last op
  } vec_t;

  op_exp_t     exp_op_q[$];
  logic [15:0] exp_rd_q[$];
  vec_t        vecs[8];

  int  checks = 0;
  int  failures = 0;
  int  mon_issued, mon_gaps, mon_wrr, mon_rd, mon_done;
  int  done_cyc, first_op_cyc, first_rd_cyc;
  bit  started = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    mon_issued = 0; mon_gaps = 0; mon_wrr = 0; mon_rd = 0; mon_done = 0;
    done_cyc = -1; first_op_cyc = -1; first_rd_cyc = -1;
  endtask

  // Advance to the next negedge and score everything the DUT shows there.
  task automatic tick();
    op_exp_t     e;
    logic [15:0] r;
    @(negedge clk);
    if (rst_n) begin
      if (arr_op_code != 2'b00) begin
        if (exp_op_q.size() == 0) begin
          chk("unexpected_op", 32'(arr_op_code), 32'd0);
        end else begin
          e = exp_op_q.pop_front();
          chk("op_code", 32'(arr_op_code), 32'(e.op));
          chk("op_addr", 32'(arr_addr), 32'(e.addr));
          if (e.chk_data) chk("op_data", 32'(arr_data_in), 32'(e.data));
          started = !e.last;
          mon_issued++;
          if (first_op_cyc < 0) first_op_cyc = cyc;
        end
      end else if (started && exp_op_q.size() > 0) begin
        mon_gaps++;
        chk("bubble_addr", 32'(arr_addr), 32'(exp_op_q[0].addr));
      end
      if (wr_ready) mon_wrr++;
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        end else begin
          r = exp_rd_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(r));
        end
        mon_rd++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (done) begin
        mon_done++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic push_burst(input logic [1:0] op, input logic [8:0] addr,
                            input logic [3:0] len, input logic [15:0] dbase);
    op_exp_t    e;
    logic [8:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 9'(i);
      if (op != C_NOP) begin
        e.op = op; e.addr = a; e.data = beat_data(dbase, i);
        e.chk_data = (op == C_WR || op == C_MAC);
        e.last = (i == int'(len));
        exp_op_q.push_back(e);
      end
      if (op == C_RD || op == C_MAC) exp_rd_q.push_back(mem_val(a));
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [8:0] addr,
                           input logic [3:0] len, output int acc);
    int g = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
    while (!cmd_ready && g < 100) begin tick(); g++; end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    acc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (mon_done < target && g < 200) begin tick(); g++; end
    chk("done_seen", 32'(mon_done >= target), 32'd1);
    repeat (RD_LAT + 2) tick();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_arr_op_code"}, 32'(arr_op_code), 32'd0);
    chk({tag, "_arr_addr"},    32'(arr_addr),    32'd0);
    chk({tag, "_arr_data_in"}, 32'(arr_data_in), 32'd0);
    chk({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
    chk({tag, "_rd_data"},     32'(rd_data),     32'd0);
    chk({tag, "_done"},        32'(done),        32'd0);
    chk({tag, "_busy"},        32'(busy),        32'd0);
    chk({tag, "_wr_ready"},    32'(wr_ready),    32'd0);
    chk({tag, "_cmd_ready"},   32'(cmd_ready),   32'd1);
  endtask

  task automatic run_case(input int idx, input vec_t v);
    int acc, n, g, beat, stall_left;
    n = int'(v.len) + 1;
    clear_mon();
    push_burst(v.op, v.addr, v.len, v.dbase);
    issue_cmd(v.op, v.addr, v.len, acc);
    if (v.op == C_WR || v.op == C_MAC) begin
      beat = 0; stall_left = v.stall_cyc; g = 0;
      while (beat < n && g < 200) begin
        if (beat == v.stall_beat && stall_left > 0) begin
          wr_valid = 1'b0; stall_left--;
        end else begin
          wr_valid = 1'b1; wr_data = beat_data(v.dbase, beat);
        end
        if (wr_valid && wr_ready) beat++;
        tick(); g++;
      end
      wr_valid = 1'b0;
      chk("beats_consumed", 32'(beat), 32'(n));
    end
    wait_done(1);
    chk("done_pulses",  32'(mon_done),         32'd1);
    chk("done_latency", 32'(done_cyc - acc),   32'(v.exp_cycles));
    chk("rd_beats",     32'(mon_rd),           32'(v.exp_rd));
    chk("wr_ready_cyc", 32'(mon_wrr),          32'(v.exp_wrr));
    chk("stall_gaps",   32'(mon_gaps),         32'(v.exp_gaps));
    chk("ops_issued",   32'(mon_issued),       32'((v.op == C_NOP) ? 0 : n));
    chk("ops_left",     32'(exp_op_q.size()),  32'd0);
    chk("rd_left",      32'(exp_rd_q.size()),  32'd0);
    if (v.exp_rd > 0)
      chk("rd_latency", 32'(first_rd_cyc - first_op_cyc), 32'(RD_LAT + 1));
    $display("case %0d op=%0d addr=%03h len=%0d ops=%0d rd=%0d done_after=%0d",
             idx, v.op, v.addr, v.len, mon_issued, mon_rd, done_cyc - acc);
    exp_op_q.delete(); exp_rd_q.delete(); started = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_a, acc_b, g;

    //            op     addr     len    dbase     sb  sc  cyc rd  wrr gaps
    vecs[0] = '{C_RD,  9'h1FE, 4'd3,  16'h0000, -1, 0,  7,  4,  0,  0};
    vecs[1] = '{C_WR,  9'd10,  4'd2,  16'h1000,  1, 3,  9,  0,  6,  3};
    vecs[2] = '{C_MAC, 9'd0,   4'd0,  16'hA5A5, -1, 0,  4,  1,  1,  0};
    vecs[3] = '{C_NOP, 9'h020, 4'd15, 16'h0000, -1, 0, 19,  0,  0,  0};
    vecs[4] = '{C_MAC, 9'h1FF, 4'd4,  16'h2000,  0, 2, 10,  5,  7,  0};
    vecs[5] = '{C_RD,  9'h100, 4'd15, 16'h0000, -1, 0, 19, 16,  0,  0};
    vecs[6] = '{C_WR,  9'h1FF, 4'd0,  16'h3000, -1, 0,  4,  0,  1,  0};
    vecs[7] = '{C_MAC, 9'h030, 4'd3,  16'h4000,  2, 1,  8,  4,  5,  1};

    clear_mon();
    repeat (3) tick();
    #1 check_idle("reset");
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) run_case(i, vecs[i]);

    // Second command held on cmd_valid during a burst: taken only on done.
    clear_mon();
    push_burst(C_RD, 9'h040, 4'd2, 16'h0);
    push_burst(C_RD, 9'h080, 4'd1, 16'h0);
    cmd_valid = 1'b1; cmd_op = C_RD; cmd_addr = 9'h040; cmd_len = 4'd2;
    g = 0;
    while (!cmd_ready && g < 100) begin tick(); g++; end
    acc_a = cyc;
    tick();
    cmd_addr = 9'h080; cmd_len = 4'd1;
    g = 0;
    while (!cmd_ready && g < 100) begin tick(); g++; end
    acc_b = cyc;
    chk("b2b_accept_on_done", 32'(done), 32'd1);
    chk("b2b_accept_cycle", 32'(acc_b - acc_a), 32'd6);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_busy_again", 32'(busy), 32'd1);
    wait_done(2);
    chk("b2b_done_pulses", 32'(mon_done), 32'd2);
    chk("b2b_latency", 32'(done_cyc - acc_b), 32'd5);
    chk("b2b_rd_beats", 32'(mon_rd), 32'd5);
    chk("b2b_ops", 32'(mon_issued), 32'd5);
    $display("b2b first_accept=%0d second_accept=%0d rd=%0d", acc_a, acc_b, mon_rd);
    exp_op_q.delete(); exp_rd_q.delete(); started = 1'b0;

    // Reset in the middle of a READ burst.
    clear_mon();
    push_burst(C_RD, 9'd5, 4'd7, 16'h0);
    issue_cmd(C_RD, 9'd5, 4'd7, acc);
    g = 0;
    while (mon_issued < 3 && g < 50) begin tick(); g++; end
    chk("midrst_reached_op3", 32'(mon_issued), 32'd3);
    rst_n = 1'b0;
    exp_op_q.delete(); exp_rd_q.delete(); started = 1'b0;
    #1 check_idle("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (12) tick();
    chk("midrst_no_done", 32'(mon_done), 32'd0);
    chk("midrst_no_rd", 32'(mon_rd), 32'd0);
    chk("midrst_no_ops", 32'(mon_issued), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    $display("midrst after_reset ops=%0d rd=%0d done=%0d", mon_issued, mon_rd, mon_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
